// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, opcodes, FSM states and fixed MAC pin patterns for mac_sequencer.
package mac_pkg;
  localparam int DATA_W = 8;
  localparam int RES_W = 17;
  localparam logic OP_SUMP = 1'b0;
  localparam logic OP_TRI = 1'b1;
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TRI_S1     = 3'd1,
    ST_TRI_S2     = 3'd2,
    ST_SUMP_WAIT  = 3'd3,
    ST_SUMP_ISSUE = 3'd4,
    ST_DRAIN      = 3'd5,
    ST_RESULT     = 3'd6
  } state_e;
  typedef struct packed {
    logic [DATA_W-1:0] in_1;
    logic [DATA_W-1:0] in_2;
    logic [DATA_W-1:0] in_add;
    logic              mode;
    logic              mul_mux;
    logic              adder_mux;
  } mac_pins_t;
  localparam mac_pins_t PINS_OFF = '0;
  // Adding zero to the accumulator keeps it intact between streamed pairs
  localparam mac_pins_t PINS_HOLD = '{in_1: 8'd0, in_2: 8'd0, in_add: 8'd0, mode: 1'b0, mul_mux: 1'b0, adder_mux: 1'b1};
endpackage

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences an external MAC unit for trinomial and sum-of-products commands.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int MAC_LATENCY = 2,
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_x,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [DATA_W-1:0] cmd_c,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_in1,
  input  logic [DATA_W-1:0] op_in2,
  output logic [DATA_W-1:0] mac_in_1,
  output logic [DATA_W-1:0] mac_in_2,
  output logic [DATA_W-1:0] mac_in_add,
  output logic              mac_mode,
  output logic              mac_mul_input_mux,
  output logic              mac_adder_input_mux,
  input  logic [RES_W-1:0]  mac_output,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              busy
);
  localparam int CNT_W = $clog2(MAC_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAC_LATENCY - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, x_q, x_d, b_q, b_d, c_q, c_d, p1_q, p1_d, p2_q, p2_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RES_W-1:0]  res_q, res_d;
  mac_pins_t         pins;

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    x_d = x_q;
    b_d = b_q;
    c_d = c_q;
    p1_d = p1_q;
    p2_d = p2_q;
    rem_d = rem_q;
    first_d = first_q;
    res_d = res_q;
    cnt_d = (state_q == ST_DRAIN) ? cnt_q + CNT_W'(1) : '0;
    pins = PINS_OFF;
    unique case (state_q)
      ST_IDLE: if (cmd_valid) begin
        a_d = cmd_a;
        x_d = cmd_x;
        b_d = cmd_b;
        c_d = cmd_c;
        rem_d = cmd_len;
        first_d = 1'b1;
        res_d = '0;
        state_d = (cmd_op == OP_TRI) ? ST_TRI_S1 : (cmd_len != '0) ? ST_SUMP_WAIT : ST_RESULT;
      end
      ST_TRI_S1: begin
        pins = '{a_q, x_q, b_q, 1'b1, 1'b0, 1'b0};
        state_d = ST_TRI_S2;
      end
      ST_TRI_S2: begin
        pins = '{a_q, x_q, c_q, 1'b1, 1'b1, 1'b0};
        state_d = ST_DRAIN;
      end
      ST_SUMP_WAIT: begin
        pins = PINS_HOLD;
        if (op_valid) begin
          p1_d = op_in1;
          p2_d = op_in2;
          rem_d = rem_q - LEN_W'(1);
          state_d = ST_SUMP_ISSUE;
        end
      end
      ST_SUMP_ISSUE: begin
        pins = '{p1_q, p2_q, 8'd0, 1'b0, 1'b0, !first_q};
        first_d = 1'b0;
        state_d = (rem_q == '0) ? ST_DRAIN : ST_SUMP_WAIT;
      end
      ST_DRAIN: if (cnt_q == CNT_LAST) begin
        res_d = mac_output;
        state_d = ST_RESULT;
      end
      ST_RESULT: state_d = res_ready ? ST_IDLE : ST_RESULT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q <= '0;
      x_q <= '0;
      b_q <= '0;
      c_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      rem_q <= '0;
      first_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      x_q <= x_d;
      b_q <= b_d;
      c_q <= c_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      rem_q <= rem_d;
      first_q <= first_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

  assign cmd_ready = state_q == ST_IDLE;
  assign busy = state_q != ST_IDLE;
  assign op_ready = state_q == ST_SUMP_WAIT;
  assign res_valid = state_q == ST_RESULT;
  assign res_data = res_q;
  assign mac_in_1 = pins.in_1;
  assign mac_in_2 = pins.in_2;
  assign mac_in_add = pins.in_add;
  assign mac_mode = pins.mode;
  assign mac_mul_input_mux = pins.mul_mux;
  assign mac_adder_input_mux = pins.adder_mux;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: randomized and directed checks of mac_sequencer against a stand-in MAC and result scoreboard.
module tb_mac_sequencer;
  localparam int L = 2;
  localparam int LEN_W = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [7:0] cmd_a = '0, cmd_x = '0, cmd_b = '0, cmd_c = '0;
  logic op_valid = 1'b0, op_ready;
  logic [7:0] op_in1 = '0, op_in2 = '0;
  logic [7:0] mac_in_1, mac_in_2, mac_in_add;
  logic mac_mode, mac_mul_input_mux, mac_adder_input_mux;
  logic [16:0] mac_output, mac_nxt;
  logic [16:0] mac_stage [L];
  logic res_valid, res_ready = 1'b0, busy;
  logic [16:0] res_data;
  int n_chk = 0, n_fail = 0;
  int exp_q[$];
  logic [7:0] pa [16], pb [16];
  int gp [16];

  always #5 clk = ~clk;

  mac_sequencer #(.MAC_LATENCY(L), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .cmd_a(cmd_a), .cmd_x(cmd_x), .cmd_b(cmd_b), .cmd_c(cmd_c),
    .op_valid(op_valid), .op_ready(op_ready), .op_in1(op_in1), .op_in2(op_in2),
    .mac_in_1(mac_in_1), .mac_in_2(mac_in_2), .mac_in_add(mac_in_add), .mac_mode(mac_mode),
    .mac_mul_input_mux(mac_mul_input_mux), .mac_adder_input_mux(mac_adder_input_mux),
    .mac_output(mac_output), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  // Stand-in MAC: accumulator updates on any non-zero pin pattern, output delayed so it is valid L cycles after an issue
  always_comb begin
    mac_nxt = mac_stage[0];
    if ({mac_in_1, mac_in_2, mac_in_add, mac_mode, mac_mul_input_mux, mac_adder_input_mux} != '0)
      mac_nxt = 17'((mac_mul_input_mux ? mac_stage[0] : 17'(mac_in_1)) * 17'(mac_in_2)
                + 17'(mac_in_add) + (mac_adder_input_mux ? mac_stage[0] : 17'd0));
  end
  initial for (int i = 0; i < L; i++) mac_stage[i] = '0;
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) mac_stage[i] <= mac_stage[i-1];
    mac_stage[0] <= mac_nxt;
  end
  assign mac_output = mac_stage[L-1];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_pins(input string nm, input logic [7:0] i1, i2, ia, input logic m, mm, am);
    chk(nm, {mac_in_1, mac_in_2, mac_in_add, mac_mode, mac_mul_input_mux, mac_adder_input_mux},
        {i1, i2, ia, m, mm, am});
  endtask

  function automatic int tri_model(int a, int x, int b, int c);
    return ((a * x + b) * x + c) % 131072;
  endfunction

  function automatic int sump_model(int len);
    int s = 0;
    for (int i = 0; i < len; i++) s += int'(pa[i]) * int'(pb[i]);
    return s % 131072;
  endfunction

  // Scoreboard: every cycle with res_valid must show the oldest outstanding expected result
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("busy_vs_cmd_ready", busy, !cmd_ready);
      if (res_valid) begin
        if (exp_q.size() == 0) chk("res_unexpected", exp_q.size(), 1);
        else chk("res_data", res_data, exp_q[0]);
      end
    end
    @(posedge clk);
    if (reset) exp_q.delete();
    else if (res_valid && res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic accept_cmd(input logic op, input logic [LEN_W-1:0] len, input logic [7:0] a, x, b, c, input int exp);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
    cmd_a = a; cmd_x = x; cmd_b = b; cmd_c = c;
    exp_q.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm, input int k0, input int lat, input int rr);
    int k = k0;
    while (!res_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_res_valid"}, res_valid, 1);
    if (lat >= 0) chk({nm, "_latency"}, k, lat);
    repeat (rr) begin
      chk({nm, "_result_hold"}, {busy, cmd_ready, res_valid}, 3'b101);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({nm, "_back_idle"}, {cmd_ready, res_valid, busy}, 3'b100);
  endtask

  task automatic send_tri(input logic [7:0] a, x, b, c, input int exp, input int rr);
    accept_cmd(1'b1, '0, a, x, b, c, exp);
    chk_pins("tri_s1_pins", a, x, b, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_pins("tri_s2_pins", a, x, c, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    wait_result("tri", 3, 3 + L, rr);
  endtask

  task automatic send_sump(input int len, input int exp, input int rr);
    accept_cmd(1'b0, LEN_W'(len), 8'd0, 8'd0, 8'd0, 8'd0, exp);
    if (len == 0) begin
      chk("sump0_op_ready", op_ready, 0);
      wait_result("sump0", 1, 1, rr);
      return;
    end
    for (int i = 0; i < len; i++) begin
      int k = 0;
      while (!op_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("sump_op_ready", op_ready, 1);
      chk_pins("sump_hold_pins", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      repeat (gp[i]) begin
        @(negedge clk);
        chk_pins("sump_gap_pins", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      end
      op_valid = 1'b1; op_in1 = pa[i]; op_in2 = pb[i];
      @(negedge clk);
      op_valid = 1'b0;
      chk("sump_issue_op_ready", op_ready, 0);
      chk_pins("sump_issue_pins", pa[i], pb[i], 8'd0, 1'b0, 1'b0, logic'(i != 0));
    end
    wait_result("sump", 0, L + 1, rr);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_status", {busy, op_ready, res_valid}, 3'b000);
    chk("rst_res_data", res_data, 0);
    chk_pins("rst_pins", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    send_tri(8'd5, 8'd3, 8'd2, 8'd1, 52, 0);
    send_tri(8'd9, 8'd8, 8'd7, 8'd6, 638, 3);
    pa[0] = 8'd5; pb[0] = 8'd3; gp[0] = 0;
    pa[1] = 8'd9; pb[1] = 8'd8; gp[1] = 2;
    pa[2] = 8'd2; pb[2] = 8'd4; gp[2] = 0;
    send_sump(3, 95, 1);
    send_sump(0, 0, 0);
    send_tri(8'd255, 8'd255, 8'd255, 8'd255, 511, 0);
    // Abort a SUMP after one pair; op_valid stays high through reset and must not be consumed
    accept_cmd(1'b0, LEN_W'(3), 8'd0, 8'd0, 8'd0, 8'd0, 95);
    op_valid = 1'b1; op_in1 = 8'd5; op_in2 = 8'd3;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", op_ready, 1);
    reset = 1'b1; op_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_status", {op_ready, res_valid, cmd_ready, busy}, 4'b0010);
    @(negedge clk);
    op_valid = 1'b0;
    chk("abort_still_idle", {cmd_ready, op_ready}, 2'b10);
    send_tri(8'd5, 8'd3, 8'd2, 8'd1, 52, 0);
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] a, x, b, c;
        a = 8'($urandom); x = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        send_tri(a, x, b, c, tri_model(a, x, b, c), $urandom_range(0, 3));
      end else begin
        int len;
        len = $urandom_range(0, 5);
        for (int i = 0; i < len; i++) begin
          pa[i] = 8'($urandom); pb[i] = 8'($urandom); gp[i] = $urandom_range(0, 2);
        end
        send_sump(len, sump_model(len), $urandom_range(0, 3));
      end
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
